mod_reduce_seq: RTL and testbench

MOD_REDUCE_SEQ -- requirements
Module: mod_reduce_seq

---
 rtl/mod_reduce_seq.sv | 127 ++++++++++++
 tb/tb_mod_reduce_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_reduce_seq.sv
// Sequential signed x mod q: restoring reduction of |x|, one bit per cycle, then a sign fix-up.
// Results are held in DONE until out_ready; out_valid rises one edge after DONE is entered.
module mod_reduce_seq #(
  parameter int DATA_W = 8,
  parameter int MOD_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  input  logic [MOD_W-1:0]  modulus,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MOD_W-1:0]  out_rem,
  output logic              out_neg,
  output logic              out_err
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               sign;
  logic               err;
  logic [DATA_W-1:0]  mag;
  logic [MOD_W-1:0]   q;
  logic [MOD_W:0]     r;
  logic [MOD_W:0]     r_shift;
  logic [MOD_W:0]     r_step;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               consume;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign consume  = (state == DONE) & out_valid & out_ready;

  // r < q always holds, so the shifted value fits in MOD_W+1 bits and one
  // conditional subtract restores the invariant.
  assign r_shift = {r[MOD_W-1:0], mag[DATA_W-1]};
  assign r_step  = (r_shift >= {1'b0, q}) ? (r_shift - {1'b0, q}) : r_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (modulus == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_nxt = FIX;
        end
      end
      FIX:     state_nxt = DONE;
      DONE: begin
        if (consume) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign      <= 1'b0;
      err       <= 1'b0;
      mag       <= '0;
      q         <= '0;
      r         <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_rem   <= '0;
      out_neg   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign <= x[DATA_W-1];
            // Two's-complement negate; the most negative value maps to 2^(DATA_W-1) unsigned.
            mag  <= x[DATA_W-1] ? (~x + 1'b1) : x;
            q    <= modulus;
            r    <= '0;
            cnt  <= CNT_W'(DATA_W - 1);
            err  <= (modulus == '0);
          end
        end
        CALC: begin
          r   <= r_step;
          mag <= {mag[DATA_W-2:0], 1'b0};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (sign && (r != '0)) begin
            r <= {1'b0, q} - r;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_rem   <= r[MOD_W-1:0];
            out_neg   <= sign;
            out_err   <= err;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Directed bench for mod_reduce_seq: hand-computed vectors, latency, hold, reset abort and a sweep.
module tb_mod_reduce_seq;
  localparam int DATA_W = 8;
  localparam int MOD_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] x = '0;
  logic [MOD_W-1:0]  modulus = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [MOD_W-1:0]  out_rem;
  logic              out_neg;
  logic              out_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mod_reduce_seq #(.DATA_W(DATA_W), .MOD_W(MOD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .modulus(modulus),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rem(out_rem), .out_neg(out_neg), .out_err(out_err)
  );

  // Present a request at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input int xv, input int qv);
    @(negedge clk);
    x        = DATA_W'(xv);
    modulus  = MOD_W'(qv);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Edges elapsed after the accepting edge until out_valid is seen; 40 means timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic apply(input int xv, input int qv, output logic [MOD_W-1:0] rem,
                       output logic neg, output logic err, output int lat);
    start_op(xv, qv);
    wait_valid(lat);
    rem = out_rem;
    neg = out_neg;
    err = out_err;
    consume();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || out_rem !== 5'd0 || out_neg !== 1'b0 || out_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b rem=%0d neg=%b err=%b, want 0/0/0/0",
               out_valid, out_rem, out_neg, out_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int tx[6]   = '{-1, -3, 30, 3, -128, 127};
    int tq[6]   = '{17, 17, 17, 17, 17, 31};
    int texp[6] = '{16, 14, 13, 3, 8, 3};
    logic [MOD_W-1:0] rem;
    logic neg, err;
    int lat;
    for (int i = 0; i < 6; i++) begin
      apply(tx[i], tq[i], rem, neg, err, lat);
      n_vec++;
      if (rem !== MOD_W'(texp[i]) || neg !== (tx[i] < 0) || err !== 1'b0) begin
        n_bad++;
        $display("FAIL basic x=%0d q=%0d: got rem=%0d neg=%b err=%b, want rem=%0d neg=%b err=0",
                 tx[i], tq[i], rem, neg, err, texp[i], tx[i] < 0);
      end
      n_vec++;
      if (lat != DATA_W + 2) begin
        n_bad++;
        $display("FAIL basic_latency x=%0d: got %0d edges want %0d", tx[i], lat, DATA_W + 2);
      end
    end
  endtask

  task automatic test_zero_mod();
    int zx[2] = '{5, -5};
    logic [MOD_W-1:0] rem;
    logic neg, err;
    int lat;
    for (int i = 0; i < 2; i++) begin
      apply(zx[i], 0, rem, neg, err, lat);
      n_vec++;
      if (rem !== 5'd0 || err !== 1'b1 || neg !== (zx[i] < 0) || lat != 1) begin
        n_bad++;
        $display("FAIL zero_mod x=%0d: got rem=%0d err=%b neg=%b lat=%0d, want 0/1/%b/1",
                 zx[i], rem, err, neg, lat, zx[i] < 0);
      end
    end
  endtask

  task automatic test_edge_values();
    logic [MOD_W-1:0] rem;
    logic neg, err;
    int lat;
    apply(-77, 1, rem, neg, err, lat);
    n_vec++;
    if (rem !== 5'd0 || err !== 1'b0 || neg !== 1'b1 || lat != DATA_W + 2) begin
      n_bad++;
      $display("FAIL mod_one: got rem=%0d err=%b neg=%b lat=%0d, want 0/0/1/10", rem, err, neg, lat);
    end
    apply(0, 17, rem, neg, err, lat);
    n_vec++;
    if (rem !== 5'd0 || neg !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL x_zero: got rem=%0d neg=%b err=%b, want 0/0/0", rem, neg, err);
    end
  endtask

  task automatic test_hold();
    int lat;
    start_op(30, 17);
    wait_valid(lat);
    x        = DATA_W'(5);
    modulus  = MOD_W'(3);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_rem !== 5'd13 ||
          out_neg !== 1'b0 || out_err !== 1'b0) begin
        n_bad++;
        $display("FAIL hold cycle %0d: got valid=%b rdy=%b rem=%0d neg=%b err=%b, want 1/0/13/0/0",
                 k, out_valid, in_ready, out_rem, out_neg, out_err);
      end
    end
    in_valid = 1'b0;
    consume();
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_release: got valid=%b rdy=%b, want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [MOD_W-1:0] rem;
    logic neg, err;
    int lat;
    logic seen;
    start_op(5, 17);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_rem !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_mid_async: got valid=%b rem=%0d, want 0/0", out_valid, out_rem);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_abort: got out_valid seen=%b want 0", seen);
    end
    apply(-2, 17, rem, neg, err, lat);
    n_vec++;
    if (rem !== 5'd15 || neg !== 1'b1 || err !== 1'b0 || lat != DATA_W + 2) begin
      n_bad++;
      $display("FAIL reset_mid_next: got rem=%0d neg=%b err=%b lat=%0d, want 15/1/0/10",
               rem, neg, err, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [MOD_W-1:0] rem;
    logic neg, err;
    int lat, xv, qv, exp_rem;
    for (int i = 0; i < 256; i++) begin
      xv = i - 128;
      qv = ((i * 7) % 31) + 1;
      exp_rem = ((xv % qv) + qv) % qv;
      apply(xv, qv, rem, neg, err, lat);
      n_vec++;
      if (rem !== MOD_W'(exp_rem) || neg !== (xv < 0) || err !== 1'b0 || lat != DATA_W + 2) begin
        n_bad++;
        $display("FAIL sweep x=%0d q=%0d: got rem=%0d neg=%b err=%b lat=%0d, want rem=%0d neg=%b err=0 lat=10",
                 xv, qv, rem, neg, err, lat, exp_rem, xv < 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_mod();
    test_edge_values();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
